// File: rtl/io_periph_bank.sv
// I/O peripheral bank for the LSU window: LED/HEX/LCD output registers,
// a programmable interval timer, and synchronised switch/key inputs with sticky key-edge flags.
module io_periph_bank #(
  parameter logic [31:0] IO_BASE = 32'h1000_0000,
  parameter int          LEDR_W  = 17,
  parameter int          LEDG_W  = 8,
  parameter int          NUM_HEX = 8,
  parameter int          SW_W    = 18,
  parameter int          KEY_W   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [31:0]          i_lsu_addr,
  input  logic [31:0]          i_st_data,
  input  logic                 i_lsu_wren,
  input  logic                 i_lsu_rden,
  input  logic [2:0]           i_bmask,
  input  logic [SW_W-1:0]      i_io_sw,
  input  logic [KEY_W-1:0]     i_io_key,
  output logic                 o_hit,
  output logic [31:0]          o_ld_data,
  output logic                 o_ld_valid,
  output logic [LEDR_W-1:0]    o_io_ledr,
  output logic [LEDG_W-1:0]    o_io_ledg,
  output logic [7*NUM_HEX-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd,
  output logic                 o_tmr_irq,
  output logic                 o_key_irq
);

  localparam logic [14:0] A_LEDR  = 15'h0000;
  localparam logic [14:0] A_LEDG  = 15'h0400;
  localparam logic [14:0] A_HEX0  = 15'h0800;
  localparam logic [14:0] A_HEX1  = 15'h0801;
  localparam logic [14:0] A_BLANK = 15'h0802;
  localparam logic [14:0] A_LCD   = 15'h1000;
  localparam logic [14:0] A_KEY   = 15'h1400;
  localparam logic [14:0] A_KEDGE = 15'h1401;
  localparam logic [14:0] A_CNT   = 15'h1800;
  localparam logic [14:0] A_CMP   = 15'h1801;
  localparam logic [14:0] A_CTRL  = 15'h1802;
  localparam logic [14:0] A_SW    = 15'h4000;

  // Masks keep HEX data and blank bits for digits at or above NUM_HEX cleared.
  localparam logic [63:0] HEX_MASK   = (64'd1 << (4 * NUM_HEX)) - 64'd1;
  localparam logic [15:0] BLANK_MASK = 16'((32'd1 << NUM_HEX) - 32'd1);

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  logic [31:0]       off, wmask, wdata, rdata;
  logic [14:0]       word;
  logic [3:0]        lanes;
  logic              misaligned, we, tmr_match;
  logic [KEY_W-1:0]  key_set, key_clr;

  logic [LEDR_W-1:0] ledr_q, ledr_d;
  logic [LEDG_W-1:0] ledg_q, ledg_d;
  logic [63:0]       hex_data_q, hex_data_d;
  logic [15:0]       hex_blank_q, hex_blank_d;
  logic [31:0]       lcd_q, lcd_d;
  logic [KEY_W-1:0]  key_s1_q, key_s1_d, key_s2_q, key_s2_d, key_prev_q, key_prev_d;
  logic [KEY_W-1:0]  key_edge_q, key_edge_d;
  logic [SW_W-1:0]   sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [31:0]       tmr_cnt_q, tmr_cnt_d, tmr_cmp_q, tmr_cmp_d;
  logic              tmr_en_q, tmr_en_d, tmr_auto_q, tmr_auto_d, tmr_status_q, tmr_status_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              ld_valid_q, ld_valid_d;

  always_comb begin
    off   = i_lsu_addr - IO_BASE;
    o_hit = off < 32'h0001_1000;
    word  = off[16:2];

    lanes      = 4'b0000;
    misaligned = 1'b0;
    case (i_bmask)
      3'b001: lanes = 4'b0001 << off[1:0];
      3'b010: begin lanes = 4'b0011 << off[1:0]; misaligned = off[0]; end
      3'b100: begin lanes = 4'b1111; misaligned = |off[1:0]; end
      default: lanes = 4'b0000;
    endcase
    we = i_lsu_wren & o_hit & ~misaligned & (|lanes);
    for (int k = 0; k < 4; k++) wmask[8*k +: 8] = {8{lanes[k]}};
    wdata = i_st_data << {off[1:0], 3'b000};

    ledr_d      = ledr_q;
    ledg_d      = ledg_q;
    hex_data_d  = hex_data_q;
    hex_blank_d = hex_blank_q;
    lcd_d       = lcd_q;
    tmr_cmp_d   = tmr_cmp_q;
    tmr_en_d    = tmr_en_q;
    tmr_auto_d  = tmr_auto_q;
    if (we && word == A_LEDR)
      ledr_d = (ledr_q & ~wmask[LEDR_W-1:0]) | (wdata[LEDR_W-1:0] & wmask[LEDR_W-1:0]);
    if (we && word == A_LEDG)
      ledg_d = (ledg_q & ~wmask[LEDG_W-1:0]) | (wdata[LEDG_W-1:0] & wmask[LEDG_W-1:0]);
    if (we && word == A_HEX0)
      hex_data_d[31:0] = (hex_data_q[31:0] & ~wmask) | (wdata & wmask);
    if (we && word == A_HEX1)
      hex_data_d[63:32] = (hex_data_q[63:32] & ~wmask) | (wdata & wmask);
    hex_data_d = hex_data_d & HEX_MASK;
    if (we && word == A_BLANK)
      hex_blank_d = ((hex_blank_q & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0])) & BLANK_MASK;
    if (we && word == A_LCD)
      lcd_d = (lcd_q & ~wmask) | (wdata & wmask);
    if (we && word == A_CMP)
      tmr_cmp_d = (tmr_cmp_q & ~wmask) | (wdata & wmask);
    if (we && word == A_CTRL) begin
      tmr_en_d   = wmask[0] ? wdata[0] : tmr_en_q;
      tmr_auto_d = wmask[1] ? wdata[1] : tmr_auto_q;
    end

    // A software write to the count takes priority over the running increment.
    tmr_match = tmr_en_q && (tmr_cnt_q == tmr_cmp_q);
    tmr_cnt_d = tmr_cnt_q;
    if (tmr_en_q) tmr_cnt_d = (tmr_match && tmr_auto_q) ? 32'd0 : tmr_cnt_q + 32'd1;
    if (we && word == A_CNT) tmr_cnt_d = (tmr_cnt_q & ~wmask) | (wdata & wmask);
    tmr_status_d = (tmr_status_q & ~(we && word == A_CTRL && wmask[2] && wdata[2])) | tmr_match;

    key_s1_d   = i_io_key;
    key_s2_d   = key_s1_q;
    key_prev_d = key_s2_q;
    sw_s1_d    = i_io_sw;
    sw_s2_d    = sw_s1_q;
    key_set    = key_prev_q & ~key_s2_q;
    key_clr    = (we && word == A_KEDGE) ? (wdata[KEY_W-1:0] & wmask[KEY_W-1:0]) : '0;
    key_edge_d = (key_edge_q & ~key_clr) | key_set;

    rdata = 32'd0;
    if (i_lsu_rden && o_hit) begin
      case (word)
        A_LEDR:  rdata = 32'(ledr_q);
        A_LEDG:  rdata = 32'(ledg_q);
        A_HEX0:  rdata = hex_data_q[31:0];
        A_HEX1:  rdata = hex_data_q[63:32];
        A_BLANK: rdata = 32'(hex_blank_q);
        A_LCD:   rdata = lcd_q;
        A_KEY:   rdata = 32'(key_s2_q);
        A_KEDGE: rdata = 32'(key_edge_q);
        A_CNT:   rdata = tmr_cnt_q;
        A_CMP:   rdata = tmr_cmp_q;
        A_CTRL:  rdata = {29'd0, tmr_status_q, tmr_auto_q, tmr_en_q};
        A_SW:    rdata = 32'(sw_s2_q);
        default: rdata = 32'd0;
      endcase
    end
    ld_data_d  = rdata;
    ld_valid_d = i_lsu_rden & o_hit;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ledr_q       <= '0;
      ledg_q       <= '0;
      hex_data_q   <= '0;
      hex_blank_q  <= '0;
      lcd_q        <= '0;
      key_s1_q     <= '1;
      key_s2_q     <= '1;
      key_prev_q   <= '1;
      key_edge_q   <= '0;
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      tmr_cnt_q    <= '0;
      tmr_cmp_q    <= '0;
      tmr_en_q     <= 1'b0;
      tmr_auto_q   <= 1'b0;
      tmr_status_q <= 1'b0;
      ld_data_q    <= '0;
      ld_valid_q   <= 1'b0;
    end else begin
      ledr_q       <= ledr_d;
      ledg_q       <= ledg_d;
      hex_data_q   <= hex_data_d;
      hex_blank_q  <= hex_blank_d;
      lcd_q        <= lcd_d;
      key_s1_q     <= key_s1_d;
      key_s2_q     <= key_s2_d;
      key_prev_q   <= key_prev_d;
      key_edge_q   <= key_edge_d;
      sw_s1_q      <= sw_s1_d;
      sw_s2_q      <= sw_s2_d;
      tmr_cnt_q    <= tmr_cnt_d;
      tmr_cmp_q    <= tmr_cmp_d;
      tmr_en_q     <= tmr_en_d;
      tmr_auto_q   <= tmr_auto_d;
      tmr_status_q <= tmr_status_d;
      ld_data_q    <= ld_data_d;
      ld_valid_q   <= ld_valid_d;
    end
  end

  always_comb begin
    o_io_hex = '0;
    for (int d = 0; d < NUM_HEX; d++)
      o_io_hex[7*d +: 7] = hex_blank_q[d] ? 7'h7F : seg7(hex_data_q[4*d +: 4]);
  end

  assign o_ld_data  = ld_data_q;
  assign o_ld_valid = ld_valid_q;
  assign o_io_ledr  = ledr_q;
  assign o_io_ledg  = ledg_q;
  assign o_io_lcd   = lcd_q;
  assign o_tmr_irq  = tmr_status_q;
  assign o_key_irq  = |key_edge_q;

endmodule

// File: tb/tb_io_periph_bank.sv
// Self-checking bench for io_periph_bank: directed walk through the main features,
// then randomized traffic compared against a byte-level behavioural model.
module tb_io_periph_bank;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] addr, stData;
  logic        wren, rden;
  logic [2:0]  bmask;
  logic [17:0] sw;
  logic [3:0]  key;

  logic        hit, ldValid, tmrIrq, keyIrq;
  logic [31:0] ldData, lcd;
  logic [16:0] ledr;
  logic [7:0]  ledg;
  logic [55:0] hex;

  int checks = 0;
  int fails  = 0;

  io_periph_bank dut (
    .i_clk(clk), .i_reset(rstN), .i_lsu_addr(addr), .i_st_data(stData),
    .i_lsu_wren(wren), .i_lsu_rden(rden), .i_bmask(bmask),
    .i_io_sw(sw), .i_io_key(key),
    .o_hit(hit), .o_ld_data(ldData), .o_ld_valid(ldValid),
    .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_hex(hex), .o_io_lcd(lcd),
    .o_tmr_irq(tmrIrq), .o_key_irq(keyIrq)
  );

  always #5 clk = ~clk;

  // Reference model state: register contents as software would see them
  logic [31:0] mLedr, mLedg, mHex0, mBlank, mLcd, mKeyEdge, mCnt, mCmp, mLdData;
  logic        mEn, mAuto, mStatus, mLdValid;
  logic [3:0]  keyHist[$];
  logic [17:0] swHist[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyphOf(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [55:0] expHex(input logic [31:0] nibbles, input logic [31:0] blank);
    logic [55:0] r;
    for (int d = 0; d < 8; d++) r[7*d +: 7] = blank[d] ? 7'h7F : glyphOf(nibbles[4*d +: 4]);
    return r;
  endfunction

  function automatic logic modelHit(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'h0001_0FFF);
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] d, input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  task automatic modelReset();
    mLedr = 0; mLedg = 0; mHex0 = 0; mBlank = 0; mLcd = 0; mKeyEdge = 0;
    mCnt = 0; mCmp = 0; mEn = 0; mAuto = 0; mStatus = 0; mLdData = 0; mLdValid = 0;
    keyHist = '{4'hF, 4'hF, 4'hF};
    swHist  = '{18'd0, 18'd0, 18'd0};
  endtask

  // keyHist/swHist hold the last three raw samples, oldest first; the
  // software-visible level is the sample taken two edges ago.
  function automatic logic [31:0] modelRead(input logic [31:0] off);
    case (off & ~32'h3)
      32'h0000_0000: return mLedr;
      32'h0000_1000: return mLedg;
      32'h0000_2000: return mHex0;
      32'h0000_2008: return mBlank;
      32'h0000_4000: return mLcd;
      32'h0000_5000: return {28'd0, keyHist[1]};
      32'h0000_5004: return mKeyEdge;
      32'h0000_6000: return mCnt;
      32'h0000_6004: return mCmp;
      32'h0000_6008: return {29'd0, mStatus, mAuto, mEn};
      32'h0001_0000: return {14'd0, swHist[1]};
      default:       return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic modelStep();
    logic [31:0] off, wmask, wdat, clrKey, nextCnt;
    logic [3:0]  lanes, keySet;
    logic        h, ok, match, clrStatus;
    int          b;
    off = addr - BASE;
    h   = modelHit(addr);
    if (rden && h) begin mLdData = modelRead(off); mLdValid = 1; end
    else begin mLdData = 0; mLdValid = 0; end

    lanes = 0; ok = 1; b = int'(off[1:0]);
    case (bmask)
      3'b001: lanes[b] = 1'b1;
      3'b010: if (off[0]) ok = 0; else begin lanes[b] = 1'b1; lanes[b+1] = 1'b1; end
      3'b100: if (off[1:0] != 0) ok = 0; else lanes = 4'hF;
      default: ok = 0;
    endcase
    for (int k = 0; k < 4; k++) wmask[8*k +: 8] = {8{lanes[k]}};
    wdat = stData << (8 * b);

    keySet  = keyHist[0] & ~keyHist[1];
    match   = mEn && (mCnt == mCmp);
    nextCnt = !mEn ? mCnt : ((match && mAuto) ? 32'd0 : mCnt + 32'd1);
    clrKey = 0; clrStatus = 0;
    if (wren && h && ok) begin
      case (off & ~32'h3)
        32'h0000_0000: mLedr  = mergeBytes(mLedr, wdat, wmask) & 32'h0001_FFFF;
        32'h0000_1000: mLedg  = mergeBytes(mLedg, wdat, wmask) & 32'h0000_00FF;
        32'h0000_2000: mHex0  = mergeBytes(mHex0, wdat, wmask);
        32'h0000_2008: mBlank = mergeBytes(mBlank, wdat, wmask) & 32'h0000_00FF;
        32'h0000_4000: mLcd   = mergeBytes(mLcd, wdat, wmask);
        32'h0000_5004: clrKey = wdat & wmask;
        32'h0000_6000: nextCnt = mergeBytes(mCnt, wdat, wmask);
        32'h0000_6004: mCmp   = mergeBytes(mCmp, wdat, wmask);
        32'h0000_6008: begin
          if (wmask[0]) mEn = wdat[0];
          if (wmask[1]) mAuto = wdat[1];
          clrStatus = wmask[2] & wdat[2];
        end
        default: ;
      endcase
    end
    mCnt     = nextCnt;
    mStatus  = (mStatus & ~clrStatus) | match;
    mKeyEdge = (mKeyEdge & ~clrKey) | {28'd0, keySet};
    keyHist.push_back(key); void'(keyHist.pop_front());
    swHist.push_back(sw);   void'(swHist.pop_front());
  endtask

  task automatic checkAll();
    checkOutput("ld_data", 64'(ldData), 64'(mLdData));
    checkOutput("ld_valid", 64'(ldValid), 64'(mLdValid));
    checkOutput("ledr", 64'(ledr), 64'(mLedr));
    checkOutput("ledg", 64'(ledg), 64'(mLedg));
    checkOutput("hex", 64'(hex), 64'(expHex(mHex0, mBlank)));
    checkOutput("lcd", 64'(lcd), 64'(mLcd));
    checkOutput("tmr_irq", 64'(tmrIrq), 64'(mStatus));
    checkOutput("key_irq", 64'(keyIrq), 64'(mKeyEdge != 0));
  endtask

  // Called just after a falling edge; drives one cycle and checks after the rising edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic we, input logic re, input logic [2:0] bm);
    addr = a; stData = d; wren = we; rden = re; bmask = bm;
    #1 checkOutput("hit", 64'(hit), 64'(modelHit(a)));
    @(posedge clk);
    modelStep();
    #1 checkAll();
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 3'b100);
  endtask

  logic [31:0] offs [14] = '{32'h0, 32'h1000, 32'h2000, 32'h2004, 32'h2008, 32'h4000, 32'h5000,
                             32'h5004, 32'h6000, 32'h6004, 32'h6008, 32'h10000, 32'h3000, 32'h10FFC};

  initial begin
    int n, sel, r;
    logic [31:0] a, d;
    logic [2:0]  bm;
    rstN = 1'b0; addr = 0; stData = 0; wren = 0; rden = 0; bmask = 3'b100;
    sw = 0; key = 4'hF;
    modelReset();

    // Reset state
    #12;
    checkOutput("rst_hex", 64'(hex), 64'({8{7'h40}}));
    checkOutput("rst_ld_valid", 64'(ldValid), 64'(0));
    checkOutput("rst_irqs", 64'({tmrIrq, keyIrq}), 64'(0));
    @(negedge clk);
    rstN = 1'b1;

    // Read LCD after reset
    applyStimulus(BASE + 32'h4000, 0, 0, 1, 3'b100);
    checkOutput("first_rd_valid", 64'(ldValid), 64'(1));
    idle();
    checkOutput("rd_valid_drop", 64'(ldValid), 64'(0));

    // Byte then halfword stores into LCD
    applyStimulus(BASE + 32'h4002, 32'hA5, 1, 0, 3'b001);
    applyStimulus(BASE + 32'h4000, 32'h1234, 1, 0, 3'b010);
    applyStimulus(BASE + 32'h4000, 0, 0, 1, 3'b100);
    checkOutput("lcd_readback", 64'(ldData), 64'(32'h00A5_1234));
    checkOutput("lcd_pins", 64'(lcd), 64'(32'h00A5_1234));

    // HEX data with the low four digits blanked
    applyStimulus(BASE + 32'h2000, 32'h0000_FEDC, 1, 0, 3'b100);
    applyStimulus(BASE + 32'h2008, 32'h0F, 1, 0, 3'b001);
    checkOutput("hex_blank", 64'(hex), 64'({{4{7'h40}}, {4{7'h7F}}}));

    // Key 1 press: edge flag appears three cycles after the raw change
    key = 4'b1101;
    idle(); idle();
    checkOutput("key_irq_early", 64'(keyIrq), 64'(0));
    idle();
    checkOutput("key_irq_cycle3", 64'(keyIrq), 64'(1));
    applyStimulus(BASE + 32'h5004, 0, 0, 1, 3'b100);
    checkOutput("key_edge_val", 64'(ldData), 64'(2));
    idle();
    key = 4'hF;
    idle(); idle(); idle();
    applyStimulus(BASE + 32'h5006, 32'hFFFF_FFFF, 1, 0, 3'b100);
    checkOutput("misaligned_drop", 64'(keyIrq), 64'(1));
    applyStimulus(BASE + 32'h5004, 32'h2, 1, 0, 3'b100);
    checkOutput("key_w1c", 64'(keyIrq), 64'(0));

    // Timer: compare 5 with auto-reload
    applyStimulus(BASE + 32'h6004, 5, 1, 0, 3'b100);
    applyStimulus(BASE + 32'h6008, 3, 1, 0, 3'b100);
    n = 0;
    while (!tmrIrq && n < 30) begin idle(); n++; end
    checkOutput("tmr_irq_timeout", 64'(tmrIrq), 64'(1));
    checkOutput("tmr_match_cycles", 64'(n), 64'(6));
    applyStimulus(BASE + 32'h6000, 0, 0, 1, 3'b100);
    checkOutput("tmr_reload", 64'(ldData), 64'(0));
    repeat (4) idle();
    applyStimulus(BASE + 32'h6008, 7, 1, 0, 3'b100);
    checkOutput("tmr_set_wins", 64'(tmrIrq), 64'(1));
    idle();
    applyStimulus(BASE + 32'h6008, 7, 1, 0, 3'b100);
    checkOutput("tmr_w1c", 64'(tmrIrq), 64'(0));
    n = 0;
    while (!tmrIrq && n < 30) begin idle(); n++; end
    checkOutput("tmr_irq2_timeout", 64'(tmrIrq), 64'(1));

    // Asynchronous reset with a read and the timer in flight
    applyStimulus(BASE + 32'h4000, 0, 0, 1, 3'b100);
    #2 rstN = 1'b0;
    #1;
    checkOutput("arst_ld_valid", 64'(ldValid), 64'(0));
    checkOutput("arst_ld_data", 64'(ldData), 64'(0));
    checkOutput("arst_tmr_irq", 64'(tmrIrq), 64'(0));
    checkOutput("arst_lcd", 64'(lcd), 64'(0));
    checkOutput("arst_hex", 64'(hex), 64'({8{7'h40}}));
    modelReset();
    @(posedge clk); #1;
    checkOutput("arst_no_valid", 64'(ldValid), 64'(0));
    @(negedge clk);
    rstN = 1'b1; rden = 0;

    // Randomized traffic against the model
    repeat (3000) begin
      sel = $urandom_range(0, 16);
      if (sel < 14) a = BASE + offs[sel] + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'd0);
      else if (sel == 14) a = BASE - 32'd4;
      else if (sel == 15) a = BASE + 32'h0001_1000;
      else a = $urandom;
      d = (sel == 8 || sel == 9) ? 32'($urandom_range(0, 15)) : $urandom;
      r = $urandom_range(0, 9);
      bm = (r < 3) ? 3'b001 : (r < 6) ? 3'b010 : (r < 9) ? 3'b100 : 3'b011;
      if ($urandom_range(0, 7) == 0) key[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) sw = 18'($urandom);
      applyStimulus(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
